// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative RV32M mul/div unit; define MULDIV_FAST_MUL_EN for single-cycle multiplies
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            zero
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t st, nx;
  logic [2:0] op_q;
  logic neg_q, neg_in, s1, s2, special, fast, quick, accept, last, ge;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] d_q, a_in, b_in, spec_val, quick_val, stage, res_q, rem_nx;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN:0] top, sh;
  function automatic logic [XLEN-1:0] fix(input logic [2:0] o, input logic n, input logic [2*XLEN-1:0] v);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0] f;
    p = n ? -v : v;
    f = o[1] ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
    return o[2] ? (n ? -f : f) : (o == 3'd0 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
  endfunction
  assign s1 = src1[XLEN-1] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
  assign s2 = src2[XLEN-1] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
  assign a_in = s1 ? -src1 : src1;
  assign b_in = s2 ? -src2 : src2;
  assign neg_in = op == 3'd6 ? s1 : s1 ^ s2;
  assign special = op[2] && (src2 == '0 || (!op[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
  assign spec_val = src2 == '0 ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_in;
  assign prod_in = {{XLEN{1'b0}}, a_in} * {{XLEN{1'b0}}, b_in};
  assign fast = !op[2];
  assign quick_val = special ? spec_val : fix(op, neg_in, prod_in);
`else
  assign fast = 1'b0;
  assign quick_val = spec_val;
`endif
  assign quick = special || fast;
  assign accept = st == IDLE && in_valid && !flush;
  assign last = cnt == CW'(XLEN - 1);
  assign top = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? d_q : {XLEN{1'b0}}};
  assign sh = acc[2*XLEN-1:XLEN-1];
  assign ge = sh >= {1'b0, d_q};
  assign rem_nx = XLEN'(sh - {1'b0, d_q});
  assign acc_nx = op_q[2] ? {ge ? rem_nx : sh[XLEN-1:0], acc[XLEN-2:0], ge} : {top, acc[XLEN-1:1]};
  assign in_ready = st == IDLE;
  assign busy = !in_ready;
  assign result_valid = st == DONE && !flush;
  assign result = result_valid ? stage : res_q;
  assign zero = result == '0;
  always_comb begin
    nx = flush ? IDLE : st == IDLE ? (in_valid ? (quick ? DONE : CALC) : IDLE) : st == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    st <= rst ? IDLE : nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      neg_q <= 1'b0;
      cnt <= '0;
      d_q <= '0;
      acc <= '0;
      stage <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        neg_q <= neg_in;
        cnt <= '0;
        d_q <= op[2] ? b_in : a_in;
        acc <= {{XLEN{1'b0}}, op[2] ? a_in : b_in};
        stage <= quick_val;
      end
      if (st == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) stage <= fix(op_q, neg_q, acc_nx);
      end
      if (result_valid) res_q <= stage;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against a behavioural RV32M model
module tb_muldiv_unit;
  parameter int XLEN = 32;
  localparam logic [XLEN-1:0] ones = '1;
  localparam logic [XLEN-1:0] min_neg = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
  localparam int lat_mul = 0;
`else
  localparam int lat_mul = XLEN;
`endif
  logic clk = 0, rst = 1, in_valid = 0, flush = 0;
  logic [2:0] op = 0;
  logic [XLEN-1:0] src1 = 0, src2 = 0;
  logic in_ready, busy, result_valid, zero;
  logic [XLEN-1:0] result;
  int total = 0, bad = 0;
  logic armed = 0, bsy = 0, rv_m;
  int c = 0;
  logic [XLEN-1:0] pend = 0, res_m = 0;
  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .flush(flush), .busy(busy), .result(result),
    .result_valid(result_valid), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [2*XLEN+1:0] x, y, p;
    logic signed [XLEN:0] sa, sb, q, r;
    logic sg1, sg2;
    sg1 = o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd6;
    sg2 = o == 3'd1 || o == 3'd4 || o == 3'd6;
    if (!o[2]) begin
      x = sg1 ? $signed(a) : $signed({1'b0, a});
      y = sg2 ? $signed(b) : $signed({1'b0, b});
      p = x * y;
      return o == 3'd0 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end
    if (b == 0) return o[1] ? a : ones;
    sa = sg1 ? $signed(a) : $signed({1'b0, a});
    sb = sg2 ? $signed(b) : $signed({1'b0, b});
    q = sa / sb;
    r = sa % sb;
    return o[1] ? r[XLEN-1:0] : q[XLEN-1:0];
  endfunction
  function automatic int lat(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == min_neg && b == ones))) return 0;
    return o[2] ? XLEN : lat_mul;
  endfunction
  function automatic logic [XLEN-1:0] rnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return ones;
      2: return min_neg;
      3: return XLEN'($urandom_range(0, 15));
      default: return XLEN'($urandom());
    endcase
  endfunction
  always @(negedge clk) begin
    if (armed) begin
      rv_m = bsy && c == 0 && !flush;
      chk("in_ready", in_ready, !bsy);
      chk("busy", busy, bsy);
      chk("result_valid", result_valid, rv_m);
      chk("result", result, rv_m ? pend : res_m);
      chk("zero", zero, (rv_m ? pend : res_m) == 0);
    end
    if (rst) begin
      bsy = 0;
      res_m = 0;
      armed = 1;
    end else if (bsy) begin
      if (flush) bsy = 0;
      else if (c == 0) begin
        bsy = 0;
        res_m = pend;
      end else c = c - 1;
    end else if (in_valid && !flush) begin
      bsy = 1;
      pend = model(op, src1, src2);
      c = lat(op, src1, src2);
    end
  end
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic ok, t;
    ok = 0;
    op = o;
    src1 = a;
    src2 = b;
    in_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      t = in_ready && !flush && !rst;
      @(posedge clk); #2;
      ok = t;
    end
    in_valid = 0;
    chk("accept", ok, 1);
  endtask
  task automatic wait_rv(output int k);
    k = 0;
    while (!result_valid && k <= XLEN + 4) begin
      @(posedge clk); #2;
      k++;
    end
  endtask
  task automatic run(input string n, input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] e, input int le);
    int k;
    issue(o, a, b);
    wait_rv(k);
    chk({n, " latency"}, XLEN'(k), XLEN'(le));
    chk(n, result, e);
    chk({n, " zero"}, zero, e == 0);
    @(posedge clk); #2;
  endtask
  initial begin
    int k, n, nops;
    logic hold, t;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset result", result, 0);
    chk("reset zero", zero, 1);
    rst = 0;
    chk("mdl mul", model(3'd0, XLEN'(7), XLEN'(-3)), XLEN'(-21));
    chk("mdl mulh", model(3'd1, ones, ones), 0);
    chk("mdl div", model(3'd4, XLEN'(-100), XLEN'(7)), XLEN'(-14));
    chk("mdl rem", model(3'd6, XLEN'(-100), XLEN'(7)), XLEN'(-2));
    chk("mdl ovf", model(3'd4, min_neg, ones), min_neg);
    run("mul", 3'd0, XLEN'(7), XLEN'(-3), XLEN'(-21), lat_mul);
    run("mul zero", 3'd0, 0, XLEN'(5), 0, lat_mul);
    run("mulhu", 3'd3, ones, ones, ones - XLEN'(1), lat_mul);
    run("mulh", 3'd1, ones, ones, 0, lat_mul);
    run("mulhsu", 3'd2, ones, ones, ones, lat_mul);
    run("divu", 3'd5, XLEN'(100), XLEN'(7), XLEN'(14), XLEN);
    run("remu", 3'd7, XLEN'(100), XLEN'(7), XLEN'(2), XLEN);
    run("div", 3'd4, XLEN'(-100), XLEN'(7), XLEN'(-14), XLEN);
    run("rem", 3'd6, XLEN'(-100), XLEN'(7), XLEN'(-2), XLEN);
    run("div by 0", 3'd4, XLEN'(5), 0, ones, 0);
    run("remu by 0", 3'd7, XLEN'('h1234), 0, XLEN'('h1234), 0);
    run("div ovf", 3'd4, min_neg, ones, min_neg, 0);
    run("rem ovf", 3'd6, min_neg, ones, 0, 0);
    issue(3'd5, XLEN'(1000), XLEN'(3));
    op = 3'd7;
    src1 = XLEN'(77);
    src2 = XLEN'(5);
    in_valid = 1;
    wait_rv(k);
    in_valid = 0;
    chk("ignore latency", XLEN'(k), XLEN'(XLEN));
    chk("ignore result", result, XLEN'(333));
    @(posedge clk); #2;
    issue(3'd5, XLEN'(200), XLEN'(9));
    repeat (9) begin @(posedge clk); #2; end
    flush = 1;
    @(posedge clk); #2;
    flush = 0;
    chk("flush in_ready", in_ready, 1);
    chk("flush busy", busy, 0);
    chk("flush result_valid", result_valid, 0);
    chk("flush result", result, XLEN'(333));
    issue(3'd5, XLEN'(200), XLEN'(9));
    repeat (4) begin @(posedge clk); #2; end
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst busy", busy, 0);
    chk("mid rst result_valid", result_valid, 0);
    chk("mid rst result", result, 0);
    chk("mid rst zero", zero, 1);
    nops = XLEN == 16 ? 200 : 1000;
    n = 0;
    hold = 0;
    for (int cyc = 0; cyc < 80000 && n < nops; cyc++) begin
      if (!hold && $urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(0, 7));
        src1 = rnd();
        src2 = rnd();
        in_valid = 1;
        hold = 1;
      end
      flush = $urandom_range(0, 199) == 0;
      rst = $urandom_range(0, 2999) == 0;
      t = hold && in_ready && !flush && !rst;
      @(posedge clk); #2;
      if (t) begin
        hold = 0;
        in_valid = 0;
        n++;
      end
    end
    in_valid = 0;
    flush = 0;
    rst = 0;
    chk("random ops issued", XLEN'(n), XLEN'(nops));
    repeat (XLEN + 4) begin @(posedge clk); #2; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
